// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM states, access-size codes and byte-count helper for mem_ctrl
package mem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, IC_RD, LSB_RD, LSB_WR} state_t;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
      return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests into byte accesses on a byte-wide RAM
// ports: clk/rst_n (sync, active-low); ic_asking/ic_addr -> ic_data/ic_data_ready (fetch);
//        lsb_req/lsb_we/lsb_size/lsb_addr/lsb_wdata -> lsb_rdata/lsb_ready (load/store);
//        flush cancels reads; mem_din/mem_dout/mem_a/mem_wr drive the RAM
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_asking,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [31:0]       ic_data,
   output logic              ic_data_ready,
   input  logic              lsb_req,
   input  logic              lsb_we,
   input  logic [1:0]        lsb_size,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [31:0]       lsb_wdata,
   output logic [31:0]       lsb_rdata,
   output logic              lsb_ready,
   input  logic              flush,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);
   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [2:0]        nb_q, nb_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       buf_q, buf_d;
   logic              ic_pend_q, ic_pend_d;
   logic [ADDR_W-1:0] ic_addr_q, ic_addr_d;
   logic              lsb_pend_q, lsb_pend_d;
   logic              l_we_q, l_we_d;
   logic [1:0]        l_sz_q, l_sz_d;
   logic [ADDR_W-1:0] l_addr_q, l_addr_d;
   logic [31:0]       l_wdata_q, l_wdata_d;
   logic [31:0]       ic_data_d, lsb_rdata_d;
   logic              ic_rdy_d, lsb_rdy_d, mem_wr_d;
   logic [7:0]        mem_dout_d;
   logic [ADDR_W-1:0] mem_a_d;
   logic              ic_new, lsb_new, ic_go, lsb_go, last;
   // reads arriving with flush are dropped; stores always survive, pending or new
   assign ic_new    = ic_asking & ~flush;
   assign lsb_new   = lsb_req & (lsb_we | ~flush);
   assign ic_go     = ic_new | (ic_pend_q & ~flush);
   assign lsb_go    = lsb_new | (lsb_pend_q & ~(flush & ~l_we_q));
   assign ic_addr_d = ic_new ? ic_addr : ic_addr_q;
   assign l_we_d    = lsb_new ? lsb_we : l_we_q;
   assign l_sz_d    = lsb_new ? lsb_size : l_sz_q;
   assign l_addr_d  = lsb_new ? lsb_addr : l_addr_q;
   assign l_wdata_d = lsb_new ? lsb_wdata : l_wdata_q;
   assign last      = {1'b0, cnt_q} == nb_q - 3'd1;
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nb_d        = nb_q;
      base_d      = base_q;
      buf_d       = buf_q;
      ic_pend_d   = ic_go;
      lsb_pend_d  = lsb_go;
      ic_data_d   = ic_data;
      lsb_rdata_d = lsb_rdata;
      ic_rdy_d    = 1'b0;
      lsb_rdy_d   = 1'b0;
      mem_wr_d    = mem_wr;
      mem_dout_d  = mem_dout;
      mem_a_d     = mem_a;
      case (state_q)
         IDLE: begin
            if (lsb_go) begin
               lsb_pend_d = 1'b0;
               base_d     = l_addr_d;
               mem_a_d    = l_addr_d;
               cnt_d      = 2'd0;
               nb_d       = size_to_bytes(l_sz_d);
               buf_d      = l_we_d ? l_wdata_d : 32'd0;
               mem_wr_d   = l_we_d;
               mem_dout_d = l_we_d ? l_wdata_d[7:0] : mem_dout;
               state_d    = l_we_d ? LSB_WR : LSB_RD;
            end else if (ic_go) begin
               ic_pend_d = 1'b0;
               base_d    = ic_addr_d;
               mem_a_d   = ic_addr_d;
               cnt_d     = 2'd0;
               nb_d      = 3'd4;
               buf_d     = 32'd0;
               state_d   = IC_RD;
            end
         end
         IC_RD, LSB_RD: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               // buffer starts cleared, so short loads come out zero-extended
               buf_d[{cnt_q, 3'b000} +: 8] = mem_din;
               if (last) begin
                  state_d     = IDLE;
                  ic_rdy_d    = state_q == IC_RD;
                  lsb_rdy_d   = state_q == LSB_RD;
                  ic_data_d   = state_q == IC_RD ? buf_d : ic_data;
                  lsb_rdata_d = state_q == LSB_RD ? buf_d : lsb_rdata;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  mem_a_d = base_q + ADDR_W'(cnt_d);
               end
            end
         end
         LSB_WR: begin
            if (last) begin
               mem_wr_d  = 1'b0;
               lsb_rdy_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d      = cnt_q + 2'd1;
               mem_a_d    = base_q + ADDR_W'(cnt_d);
               mem_dout_d = buf_q[{cnt_d, 3'b000} +: 8];
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 2'd0;
         nb_q          <= 3'd0;
         base_q        <= '0;
         buf_q         <= 32'd0;
         ic_pend_q     <= 1'b0;
         ic_addr_q     <= '0;
         lsb_pend_q    <= 1'b0;
         l_we_q        <= 1'b0;
         l_sz_q        <= 2'd0;
         l_addr_q      <= '0;
         l_wdata_q     <= 32'd0;
         ic_data       <= 32'd0;
         ic_data_ready <= 1'b0;
         lsb_rdata     <= 32'd0;
         lsb_ready     <= 1'b0;
         mem_dout      <= 8'd0;
         mem_a         <= '0;
         mem_wr        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         nb_q          <= nb_d;
         base_q        <= base_d;
         buf_q         <= buf_d;
         ic_pend_q     <= ic_pend_d;
         ic_addr_q     <= ic_addr_d;
         lsb_pend_q    <= lsb_pend_d;
         l_we_q        <= l_we_d;
         l_sz_q        <= l_sz_d;
         l_addr_q      <= l_addr_d;
         l_wdata_q     <= l_wdata_d;
         ic_data       <= ic_data_d;
         ic_data_ready <= ic_rdy_d;
         lsb_rdata     <= lsb_rdata_d;
         lsb_ready     <= lsb_rdy_d;
         mem_dout      <= mem_dout_d;
         mem_a         <= mem_a_d;
         mem_wr        <= mem_wr_d;
      end
   end
endmodule
